// File: rtl/parity_frame_serializer_if.sv
// ----------------------------------------------------------------------------
// parity_frame_serializer_if
//
// Bundles the parallel load handshake and the serial frame outputs of
// parity_frame_serializer.
//
//   data_in    [WIDTH-1:0]  parallel word offered by the producer
//   load                    data_in is valid
//   ready                   serializer can accept a word
//   frame_clr               one-cycle clear pulse for the downstream checker
//   bit_out                 current serial bit (MSB first)
//   bit_valid               bit_out carries a data bit this cycle
//   bit_last                bit_out is the final (LSB) bit of the frame
//   exp_parity              XOR-reduction of the captured word
//   frame_done              one-cycle pulse in the cycle after the last bit
//
// Modports:
//   master - producer / consumer side (drives data_in and load)
//   slave  - the serializer itself
// ----------------------------------------------------------------------------
interface parity_frame_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             frame_clr;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_last;
  logic             exp_parity;
  logic             frame_done;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  frame_clr,
    input  bit_out,
    input  bit_valid,
    input  bit_last,
    input  exp_parity,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output frame_clr,
    output bit_out,
    output bit_valid,
    output bit_last,
    output exp_parity,
    output frame_done
  );

endinterface

// File: rtl/parity_frame_serializer.sv
// ----------------------------------------------------------------------------
// parity_frame_serializer
//
// Feeds a serial odd-parity checker. A word accepted over load/ready is
// announced with a one-cycle frame_clr pulse (used as the checker's reset),
// then shifted out MSB-first one bit per clock, followed by a frame_done
// pulse and GAP_CYCLES idle cycles before ready returns. The reference
// parity of the captured word is published on exp_parity for the duration
// of the frame.
//
// Parameters:
//   WIDTH       word length in bits (>= 1)
//   GAP_CYCLES  idle cycles after the last bit before ready reasserts (>= 0)
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-high reset; aborts any frame in flight
//   bus    handshake and serial outputs (slave side of the interface)
//
// Every output is a flop. The output decode therefore works on next-state
// values, so each strobe lines up with the cycle the FSM is actually in.
// ----------------------------------------------------------------------------
module parity_frame_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  parity_frame_serializer_if.slave    bus
);

  // One counter is shared by SHIFT (bit index) and GAP (idle count).
  localparam int CMAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SHIFT,
    GAP
  } state_e;

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] sreg_q,       sreg_d;
  logic [CW-1:0]    cnt_q,        cnt_d;
  logic             accept;

  logic             ready_q,      ready_d;
  logic             frame_clr_q,  frame_clr_d;
  logic             bit_out_q,    bit_out_d;
  logic             bit_valid_q,  bit_valid_d;
  logic             bit_last_q,   bit_last_d;
  logic             exp_parity_q, exp_parity_d;
  logic             frame_done_q, frame_done_d;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      frame_clr_q  <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_last_q   <= 1'b0;
      exp_parity_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      frame_clr_q  <= frame_clr_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      bit_last_q   <= bit_last_d;
      exp_parity_q <= exp_parity_d;
      frame_done_q <= frame_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic (FSM, shift register, counter)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Qualify with the registered ready: in the first cycle after reset
        // the FSM is already in IDLE but ready is still low.
        if (bus.load && ready_q) begin
          accept  = 1'b1;
          sreg_d  = bus.data_in;
          state_d = CLR;
        end
      end

      CLR: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        // The first bit is taken from the unshifted word on entry; each
        // SHIFT cycle then advances the next bit into the MSB position.
        sreg_d = sreg_q << 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == LAST_GAP) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (values the output flops take at the coming edge)
  // --------------------------------------------------------------------------
  always_comb begin
    ready_d      = (state_d == IDLE);
    frame_clr_d  = (state_d == CLR);
    bit_valid_d  = (state_d == SHIFT);
    bit_out_d    = bit_valid_d & sreg_d[WIDTH-1];
    bit_last_d   = bit_valid_d && (cnt_d == LAST_BIT);
    frame_done_d = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    // Parity is held through the frame_done cycle even when GAP_CYCLES==0
    // puts that cycle in IDLE; it is cleared on any later IDLE cycle.
    if (accept) begin
      exp_parity_d = ^bus.data_in;
    end else if ((state_d == IDLE) && !frame_done_d) begin
      exp_parity_d = 1'b0;
    end else begin
      exp_parity_d = exp_parity_q;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.frame_clr  = frame_clr_q;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.bit_last   = bit_last_q;
  assign bus.exp_parity = exp_parity_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/parity_frame_serializer.md
Name: parity_frame_serializer

Overview:
- Upstream feeder for the serial odd-parity FSM checker.
- Accepts a parallel word over a valid/ready handshake and issues a one-cycle frame-clear pulse that drives the checker's reset.
- Then shifts the word out MSB-first, one bit per clock, and holds an inter-frame gap before accepting the next word.
- Also publishes the reference parity of the captured word so a bench can cross-check the checker output.

Parameters:
- WIDTH, 8, word length in bits (>= 1).
- GAP_CYCLES, 2, idle cycles after the last bit before ready reasserts (>= 0).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  WIDTH  parallel word to serialize
- load  input  1  data_in valid
- ready  output  1  block can accept a word
- frame_clr  output  1  one-cycle pulse that clears the downstream parity FSM
- bit_out  output  1  current serial bit
- bit_valid  output  1  bit_out is a data bit this cycle
- bit_last  output  1  bit_out is the final (LSB) bit of the frame
- exp_parity  output  1  XOR-reduction of captured word; 1 = odd number of ones; valid while frame is active
- frame_done  output  1  one-cycle pulse in the first cycle after the last bit

Behaviour:
- Registers and reset:
  - All outputs are registered.
  - Reset sampled high at an edge: state=IDLE, shift register=0, counter=0, all outputs 0.
  - ready rises in the first cycle after reset is sampled low.
- FSM states: IDLE, CLR, SHIFT, GAP.
- IDLE:
  - ready=1.
  - load&ready at edge N captures data_in into the shift register and exp_parity=^data_in, drops ready, and enters CLR.
- CLR (cycle N+1):
  - frame_clr=1, bit_valid=0.
  - Next state is SHIFT.
- SHIFT (cycles N+2 .. N+1+WIDTH):
  - bit_valid=1.
  - bit_out = shift register MSB.
  - The shift register shifts left by one each cycle, filling with 0.
  - The counter counts 0..WIDTH-1.
  - bit_last=1 only when count==WIDTH-1.
- Leaving SHIFT:
  - bit_valid=0, bit_out=0, frame_done=1 for exactly one cycle (N+2+WIDTH).
  - If GAP_CYCLES==0, go directly to IDLE. In that case ready=1 in cycle N+2+WIDTH, coincident with frame_done.
  - Otherwise enter GAP.
- GAP:
  - Lasts GAP_CYCLES cycles with all strobes 0.
  - Then IDLE; ready=1 in cycle N+2+WIDTH+GAP_CYCLES.
- exp_parity:
  - Holds its value from capture through the frame_done cycle.
  - Cleared to 0 when the FSM returns to IDLE.
- Throughput: one word per WIDTH+2+GAP_CYCLES cycles.
- load while ready=0: ignored; data_in is not sampled and there is no error flag.
- load held high continuously: a new word is accepted on the first edge on which ready=1 is sampled.
- Changes to data_in after capture have no effect on the frame in flight.
- Reset mid-frame (any state): abort immediately to IDLE.
  - No frame_done is emitted.
  - Remaining bits are dropped.
  - frame_clr is not emitted by the reset itself.
- Reset and load in the same cycle: reset wins; the word is not captured.
- WIDTH==1: SHIFT lasts one cycle, with bit_valid and bit_last high together.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then 0.
  - Required: all outputs 0 while reset is sampled high; ready=1 from the first cycle after release.
- Basic frame, WIDTH=3, GAP_CYCLES=2, data_in=3'b101:
  - frame_clr high for one cycle after acceptance.
  - bit_out = 1,0,1 with bit_valid high 3 cycles, and bit_last on the third bit.
  - exp_parity=0; frame_done pulse next cycle.
  - ready returns exactly 2 cycles later.
- Parity sweep, WIDTH=3:
  - Stimulus: data_in 0..7 back-to-back with load held high.
  - Required: exp_parity = 0,1,1,0,1,0,0,1.
  - Required: every frame spaced 7 cycles apart (WIDTH+2+GAP_CYCLES).
- Ignored load, WIDTH=8:
  - Stimulus: accept 8'hA5; pulse load with 8'hFF during SHIFT.
  - Required: serial stream 1,0,1,0,0,1,0,1; exp_parity=0; 8'hFF never transmitted.
- Reset mid-frame, WIDTH=8:
  - Stimulus: accept 8'h3C; assert reset on the 4th data bit.
  - Required: the next cycle has bit_valid=0; no frame_done; ready=1 after release.
  - Required: the next word 8'h01 serializes cleanly with exp_parity=1.
- GAP_CYCLES=0, WIDTH=1:
  - Stimulus: data_in=1 then 0 back-to-back.
  - Required: each frame is 3 cycles (CLR, one bit with bit_valid and bit_last high, then a frame_done/ready cycle).
  - Required: exp_parity values 1 then 0.
